// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbitration wrapper.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_NEG = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    // Bit positions inside the 4-bit flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // Requester ids
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // Response buffer occupancy
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu.sv
// Purpose: 4-bit combinational ALU with carry/overflow/zero/negative flags.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: in1_i/in2_i operands, op_i opcode, out_o result, flags_o {n,z,o,c}.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] in1_i,
    input  logic [3:0] in2_i,
    input  logic [2:0] op_i,
    output logic [3:0] out_o,
    output logic [3:0] flags_o
);

    logic [4:0] sum;
    logic [3:0] res;
    logic       c;
    logic       o;

    always_comb begin
        sum = 5'd0;
        res = 4'd0;
        c   = 1'b0;
        o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum = {1'b0, in1_i} + {1'b0, in2_i};
                res = sum[3:0];
                c   = sum[4];
                o   = (in1_i[3] == in2_i[3]) && (res[3] != in1_i[3]);
            end
            OP_SUB: begin
                // c is the carry out of in1 + ~in2 + 1, i.e. 1 means "no borrow"
                sum = {1'b0, in1_i} + {1'b0, ~in2_i} + 5'd1;
                res = sum[3:0];
                c   = sum[4];
                o   = (in1_i[3] != in2_i[3]) && (res[3] != in1_i[3]);
            end
            OP_AND: res = in1_i & in2_i;
            OP_OR:  res = in1_i | in2_i;
            OP_XOR: res = in1_i ^ in2_i;
            OP_NOT: res = ~in1_i;
            OP_NEG: begin
                sum = {1'b0, ~in1_i} + 5'd1;
                res = sum[3:0];
                c   = sum[4];
                o   = (in1_i == 4'b1000);
            end
            OP_SHL: begin
                res = {in1_i[2:0], 1'b0};
                c   = in1_i[3];
                o   = in1_i[3] ^ in1_i[2];
            end
            default: res = 4'd0;
        endcase
    end

    assign out_o            = res;
    assign flags_o[FLAG_C]  = c;
    assign flags_o[FLAG_O]  = o;
    assign flags_o[FLAG_Z]  = (res == 4'd0);
    assign flags_o[FLAG_N]  = res[3];

endmodule

// File: rtl/rr_arb2.sv
// Purpose: two-input round-robin grant; on a tie the input that did not win last gets it.
// Latency: combinational. Backpressure: none; caller decides whether the grant is consumed.
// Ports: req0_i/req1_i requests, last_i previous winner, gnt_vld_o any grant, gnt_id_o winner.
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_vld_o = req0_i | req1_i;
        gnt_id_o  = 1'b0;
        if (req0_i && req1_i) begin
            gnt_id_o = ~last_i;
        end else if (req1_i) begin
            gnt_id_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one 4-bit alu between requesters A/B with round-robin grant and a 1-entry response buffer.
// Latency: result visible one cycle after acceptance; one op per cycle while rsp_ready is held high.
// Backpressure: buffer full and rsp_ready low -> both readies low, response outputs held stable.
// Ports: clk/reset (async active-high); a_*/b_* valid/ready requests with in1/in2/op;
//        rsp_valid/rsp_ready response handshake with rsp_id, rsp_out, rsp_flags.
// Option: define ALU_ARB_STATS_EN to add saturating a_grants/b_grants transfer counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [W-1:0]  a_in1,
    input  logic [W-1:0]  a_in2,
    input  logic [2:0]    a_op,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [W-1:0]  b_in1,
    input  logic [W-1:0]  b_in2,
    input  logic [2:0]    b_op,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [W-1:0]  rsp_out,
    output logic [3:0]    rsp_flags
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] a_grants,
    output logic [CNT_W-1:0] b_grants
`endif
);

    if (W != 4) begin : g_bad_w
        $error("alu_arbiter: W must be 4 to match alu");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("alu_arbiter: CNT_W must be at least 1");
    end

    buf_state_t state_q, state_d;
    logic [W-1:0] rsp_out_q, rsp_out_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_id_q, rsp_id_d;
    logic         last_grant_q, last_grant_d;

    logic         gnt_vld;
    logic         gnt_id;
    logic         can_accept;
    logic         xfer;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_out;
    logic [3:0]   alu_flags;

    rr_arb2 u_arb (
        .req0_i    (a_valid),
        .req1_i    (b_valid),
        .last_i    (last_grant_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // Drain and refill in the same cycle is allowed. Reset gating keeps the
    // readies quiet while the buffer is being held empty asynchronously.
    assign can_accept = (state_q == BUF_EMPTY) || rsp_ready;
    assign xfer       = gnt_vld && can_accept && !reset;
    assign a_ready    = xfer && (gnt_id == ID_A);
    assign b_ready    = xfer && (gnt_id == ID_B);

    assign alu_in1 = (gnt_id == ID_B) ? b_in1 : a_in1;
    assign alu_in2 = (gnt_id == ID_B) ? b_in2 : a_in2;
    assign alu_op  = (gnt_id == ID_B) ? b_op  : a_op;

    alu u_alu (
        .in1_i   (alu_in1),
        .in2_i   (alu_in2),
        .op_i    (alu_op),
        .out_o   (alu_out),
        .flags_o (alu_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BUF_EMPTY;
            rsp_out_q    <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= ID_A;
            last_grant_q <= ID_B;   // so A wins the first tie
        end else begin
            state_q      <= state_d;
            rsp_out_q    <= rsp_out_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rsp_out_d    = rsp_out_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            BUF_EMPTY: begin
                if (xfer) begin
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (xfer) begin
                    state_d = BUF_FULL;
                end else if (rsp_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (xfer) begin
            rsp_out_d    = alu_out;
            rsp_flags_d  = alu_flags;
            rsp_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end
    end

    assign rsp_valid = (state_q == BUF_FULL);
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] a_grants_q, a_grants_d;
    logic [CNT_W-1:0] b_grants_q, b_grants_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_grants_q <= '0;
            b_grants_q <= '0;
        end else begin
            a_grants_q <= a_grants_d;
            b_grants_q <= b_grants_d;
        end
    end

    // Saturating counters: stick at all-ones rather than wrap.
    always_comb begin
        a_grants_d = a_grants_q;
        b_grants_d = b_grants_q;
        if (a_ready && (a_grants_q != {CNT_W{1'b1}})) begin
            a_grants_d = a_grants_q + CNT_W'(1);
        end
        if (b_ready && (b_grants_q != {CNT_W{1'b1}})) begin
            b_grants_d = b_grants_q + CNT_W'(1);
        end
    end

    assign a_grants = a_grants_q;
    assign b_grants = b_grants_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset state, single requesters, ties,
// backpressure, async reset of a pending response and optional grant counters.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [3:0] a_in1, a_in2, b_in1, b_in2;
    logic [2:0] a_op, b_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_out, rsp_flags;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] a_grants, b_grants;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .a_op      (a_op),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_in1     (b_in1),
        .b_in2     (b_in2),
        .b_op      (b_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags)
`ifdef ALU_ARB_STATS_EN
        ,
        .a_grants  (a_grants),
        .b_grants  (b_grants)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [3:0] i1, input logic [3:0] i2, input logic [2:0] op);
        a_valid = v; a_in1 = i1; a_in2 = i2; a_op = op;
    endtask

    task automatic set_b(input logic v, input logic [3:0] i1, input logic [3:0] i2, input logic [2:0] op);
        b_valid = v; b_in1 = i1; b_in2 = i2; b_op = op;
    endtask

    // A-only vectors: in1, in2, op, expected out, expected flags {n,z,o,c}
    typedef struct {
        logic [3:0] i1;
        logic [3:0] i2;
        logic [2:0] op;
        logic [3:0] out;
        logic [3:0] flg;
    } vec_t;

    vec_t vecs[5] = '{
        '{4'd5, 4'd10, 3'd2, 4'd0,  4'b0100},   // 5 & 10 = 0 -> z
        '{4'd5, 4'd0,  3'd7, 4'd10, 4'b1010},   // 5 << 1 = 10 -> n, o
        '{4'd0, 4'd0,  3'd6, 4'd0,  4'b0101},   // -0 = 0 -> z, c
        '{4'd7, 4'd1,  3'd0, 4'd8,  4'b1010},   // 7 + 1 = 8 -> n, o
        '{4'd3, 4'd0,  3'd5, 4'd12, 4'b1000}    // ~3 = 12 -> n
    };

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b0;
        set_a(1'b1, 4'd1, 4'd1, 3'd0);
        set_b(1'b1, 4'd1, 4'd1, 3'd0);
        tick();
        tick();

        // Reset state, with both requests pending: no ready pulses
        check("rst_valid", rsp_valid, 0);
        check("rst_id",    rsp_id,    0);
        check("rst_out",   rsp_out,   0);
        check("rst_flags", rsp_flags, 0);
        check("rst_a_rdy", a_ready,   0);
        check("rst_b_rdy", b_ready,   0);
        set_a(1'b0, 4'd0, 4'd0, 3'd0);
        set_b(1'b0, 4'd0, 4'd0, 3'd0);
        reset = 1'b0;
        tick();

        // 1: A alone, 14 + 4
        set_a(1'b1, 4'd14, 4'd4, 3'd0);
        rsp_ready = 1'b1;
        #1;
        check("t1_a_rdy", a_ready, 1);
        check("t1_b_rdy", b_ready, 0);
        tick();
        a_valid = 1'b0;
        check("t1_valid", rsp_valid, 1);
        check("t1_id",    rsp_id,    0);
        check("t1_out",   rsp_out,   2);
        check("t1_flags", rsp_flags, 4'b0001);

        // 2: B alone, 2 - 3
        set_b(1'b1, 4'd2, 4'd3, 3'd1);
        #1;
        check("t2_b_rdy", b_ready, 1);
        check("t2_a_rdy", a_ready, 0);
        tick();
        b_valid = 1'b0;
        check("t2_id",    rsp_id,    1);
        check("t2_out",   rsp_out,   15);
        check("t2_flags", rsp_flags, 4'b1000);
        tick();
        check("t2_drain", rsp_valid, 0);

        // A-only table
        foreach (vecs[i]) begin
            set_a(1'b1, vecs[i].i1, vecs[i].i2, vecs[i].op);
            tick();
            a_valid = 1'b0;
            check($sformatf("v%0d_out", i),   rsp_out,   vecs[i].out);
            check($sformatf("v%0d_flags", i), rsp_flags, vecs[i].flg);
        end
        tick();

        // 3: tie after reset -> A then B, readies exclusive
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_a(1'b1, 4'd9, 4'd14, 3'd2);
        set_b(1'b1, 4'd9, 4'd4,  3'd3);
        rsp_ready = 1'b1;
        #1;
        check("t3_a_rdy0", a_ready, 1);
        check("t3_b_rdy0", b_ready, 0);
        tick();
        check("t3_id0",    rsp_id,  0);
        check("t3_out0",   rsp_out, 8);
        check("t3_flags0", rsp_flags, 4'b1000);
        check("t3_a_rdy1", a_ready, 0);
        check("t3_b_rdy1", b_ready, 1);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("t3_id1",  rsp_id,  1);
        check("t3_out1", rsp_out, 13);

        // 4: backpressure with a held B response, both requesters waiting
        rsp_ready = 1'b0;
        set_a(1'b1, 4'd9, 4'd4, 3'd4);
        set_b(1'b1, 4'd2, 4'd3, 3'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_a_rdy", a_ready,   0);
            check("t4_b_rdy", b_ready,   0);
            check("t4_valid", rsp_valid, 1);
            check("t4_id",    rsp_id,    1);
            check("t4_out",   rsp_out,   13);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_a_rdy_rel", a_ready, 1);
        check("t4_b_rdy_rel", b_ready, 0);
        tick();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        rsp_ready = 1'b0;
        check("t4_id_rel",  rsp_id,  0);
        check("t4_out_rel", rsp_out, 13);

        // 5: async reset discards the pending A response; tie then goes to A
        #2;
        reset = 1'b1;
        #1;
        check("t5_valid_async", rsp_valid, 0);
        check("t5_out_async",   rsp_out,   0);
        tick();
        reset = 1'b0;
        set_a(1'b1, 4'd9, 4'd4, 3'd4);
        set_b(1'b1, 4'd2, 4'd3, 3'd1);
        rsp_ready = 1'b1;
        #1;
        check("t5_a_rdy", a_ready, 1);
        check("t5_b_rdy", b_ready, 0);
        tick();
        check("t5_id0",  rsp_id,  0);
        check("t5_out0", rsp_out, 13);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("t5_id1",    rsp_id,    1);
        check("t5_out1",   rsp_out,   15);
        check("t5_flags1", rsp_flags, 4'b1000);
        tick();

`ifdef ALU_ARB_STATS_EN
        // 6: grant counters saturate
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_a_cnt_rst", a_grants, 0);
        check("t6_b_cnt_rst", b_grants, 0);
        set_a(1'b1, 4'd1, 4'd1, 3'd0);
        rsp_ready = 1'b1;
        repeat (300) tick();
        a_valid = 1'b0;
        tick();
        check("t6_a_cnt", a_grants, 255);
        check("t6_b_cnt", b_grants, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
